enable_encoder: RTL



---
 rtl/enable_encoder_pkg.sv | 17 +
 rtl/enable_encoder_if.sv | 28 ++
 rtl/enable_encoder_prio_sel.sv | 38 +++
 rtl/enable_encoder.sv | 113 +++++++++++
 4 files changed

// File: rtl/enable_encoder_pkg.sv
// Shared constants and types for the register-bank enable encoder.
// Both the destination decoder and this encoder use these constants.
package enable_encoder_pkg;

  // Number of registers, which is also the width of the enable vector.
  localparam int N_REGS = 16;

  // Width of a binary register index.
  localparam int IDX_W  = $clog2(N_REGS);

  // IDLE waits for a vector. EMIT streams out that vector's indices.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/enable_encoder_if.sv
// Handshake bundle for enable_encoder.
// Request side: req_vec / req_valid / req_ready.
// Response side: dest / dest_valid / dest_ready / last, plus the zero_req pulse.
interface enable_encoder_if;
  import enable_encoder_pkg::*;

  logic [N_REGS-1:0] req_vec;
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  dest;
  logic              dest_valid;
  logic              dest_ready;
  logic              last;
  logic              zero_req;

  // The producer and consumer surrounding the encoder.
  modport master (
    output req_vec, req_valid, dest_ready,
    input  req_ready, dest, dest_valid, last, zero_req
  );

  // The encoder itself.
  modport slave (
    input  req_vec, req_valid, dest_ready,
    output req_ready, dest, dest_valid, last, zero_req
  );

endinterface

// File: rtl/enable_encoder_prio_sel.sv
// enable_prio_sel: combinational priority picker.
// Returns the first set bit of i_vec at or above i_ptr, wrapping from the top
// index back to 0. It also returns i_vec with that bit cleared.
// With i_ptr tied to 0 this is plain lowest-index priority.
module enable_prio_sel
  import enable_encoder_pkg::*;
(
  input  logic [N_REGS-1:0] i_vec,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic              o_found,
  output logic [IDX_W-1:0]  o_idx,
  output logic [N_REGS-1:0] o_vec_clr
);

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_pos;
  logic [N_REGS-1:0] w_onehot;

  // Scan the vector downward from offset N_REGS-1 to offset 0, relative to the pointer.
  // The last hit wins, so the result is the set bit closest above i_ptr.
  // Index arithmetic is IDX_W bits wide, so the wrap from 15 to 0 needs no extra logic.
  always_comb begin
    w_idx = '0;
    w_pos = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      w_pos = i[IDX_W-1:0] + i_ptr;
      if (i_vec[w_pos]) begin
        w_idx = w_pos;
      end
    end
  end

  assign o_found   = |i_vec;
  assign o_idx     = w_idx;
  assign w_onehot  = {{(N_REGS-1){1'b0}}, 1'b1} << w_idx;
  assign o_vec_clr = i_vec & ~w_onehot;

endmodule

// File: rtl/enable_encoder.sv
// enable_encoder: serialises a multi-hot register write-enable vector into
// binary register indices, one index per handshake.
// Optional build macro: ENC_ROUND_ROBIN_EN.
//   When defined, selection starts at a rotation pointer that persists across
//   vectors and holds (last emitted index + 1) mod N_REGS.
//   When undefined, the lowest set bit is always chosen first.
module enable_encoder
  import enable_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  enable_encoder_if.slave   bus
);

  state_t            r_state;
  logic [N_REGS-1:0] r_pending;
  logic [IDX_W-1:0]  r_dest;
  logic              r_dest_valid;
  logic              r_last;
  logic              r_zero_req;

  logic              w_idle;
  logic              w_accept;
  logic              w_advance;
  logic [N_REGS-1:0] w_sel_vec;
  logic [IDX_W-1:0]  w_sel_ptr;
  logic              w_found;
  logic [IDX_W-1:0]  w_idx;
  logic [N_REGS-1:0] w_vec_clr;

  assign w_idle    = (r_state == IDLE);
  assign w_accept  = w_idle && bus.req_valid;
  // In EMIT, dest_valid is always high, so dest_ready alone completes a handshake.
  assign w_advance = (r_state == EMIT) && bus.dest_ready;

  // One picker is shared. In IDLE it looks at the incoming vector.
  // In EMIT it looks at the captured remainder, so later changes on req_vec have no effect.
  assign w_sel_vec = w_idle ? bus.req_vec : r_pending;

`ifdef ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;

  // Each time a new index is loaded, move the pointer one past that index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if ((w_accept || w_advance) && w_found) begin
      r_ptr <= w_idx + IDX_W'(1);
    end
  end

  assign w_sel_ptr = r_ptr;
`else
  assign w_sel_ptr = '0;
`endif

  enable_prio_sel u_prio_sel (
    .i_vec     (w_sel_vec),
    .i_ptr     (w_sel_ptr),
    .o_found   (w_found),
    .o_idx     (w_idx),
    .o_vec_clr (w_vec_clr)
  );

  // Control FSM. Captures a vector, then emits one index per accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_dest       <= '0;
      r_dest_valid <= 1'b0;
      r_last       <= 1'b0;
      r_zero_req   <= 1'b0;
    end else begin
      // An all-zero vector is consumed with no indices; flag it for one cycle.
      r_zero_req <= w_accept && !w_found;
      case (r_state)
        IDLE: begin
          if (w_accept && w_found) begin
            r_dest       <= w_idx;
            r_dest_valid <= 1'b1;
            r_last       <= (w_vec_clr == '0);
            r_pending    <= w_vec_clr;
            r_state      <= EMIT;
          end
        end
        EMIT: begin
          if (w_advance) begin
            if (w_found) begin
              r_dest    <= w_idx;
              r_last    <= (w_vec_clr == '0);
              r_pending <= w_vec_clr;
            end else begin
              r_dest_valid <= 1'b0;
              r_last       <= 1'b0;
              r_state      <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_idle;
  assign bus.dest       = r_dest;
  assign bus.dest_valid = r_dest_valid;
  assign bus.last       = r_last;
  assign bus.zero_req   = r_zero_req;

endmodule
